// File: rtl/io_input_pkg.sv
// ============================================================================
// Module : io_input_pkg
// Brief  : Shared word width and IO_STATE encodings for the subleq I/O devices.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_input_pkg;

  localparam int IO_WORD_SIZE  = 16;
  localparam int IO_STATE_BITS = 2;

  typedef enum logic [IO_STATE_BITS-1:0] {
    IO_WAITREQ = 2'd0,
    IO_DOWORK  = 2'd1,
    IO_WAITACK = 2'd2
  } io_state_e;

endpackage

`default_nettype wire

// File: rtl/io_byte_fifo.sv
// ============================================================================
// Module : io_byte_fifo
// Brief  : Byte FIFO with wrap-bit pointers; head byte is visible on dout.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       areset_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign full    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign empty   = (wr_q == rd_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/io_input.sv
// ============================================================================
// Module : io_input
// Brief  : CPU read-side input device: buffers source bytes, returns one
//          zero-extended byte per four-phase req/ack handshake.
//          Define IO_INPUT_EOF_EN to add src_eof and the all-ones EOF word.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_input
  import io_input_pkg::*;
#(
  parameter int WORD_SIZE  = IO_WORD_SIZE,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic                 req,
  output logic                 ack,
  output logic [WORD_SIZE-1:0] data,
  input  logic                 src_valid,
  input  logic [7:0]           src_data,
  output logic                 src_ready
`ifdef IO_INPUT_EOF_EN
  ,
  input  logic                 src_eof
`endif
);

  io_state_e            state_q, state_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [7:0]           fifo_head;

  // Ready is gated by the reset pin so the source sees it low throughout reset.
  assign src_ready = areset_n && !fifo_full;

  io_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .areset_n (areset_n),
    .push     (src_valid && src_ready),
    .pop      (fifo_pop),
    .din      (src_data),
    .dout     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef IO_INPUT_EOF_EN
  logic eof_q, eof_d;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) eof_q <= 1'b0;
    else           eof_q <= eof_d;
  end
`endif

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= IO_WAITREQ;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    fifo_pop = 1'b0;
`ifdef IO_INPUT_EOF_EN
    eof_d    = eof_q;
`endif
    case (state_q)
      IO_WAITREQ: begin
        if (req && !fifo_empty) begin
          state_d = IO_DOWORK;
`ifdef IO_INPUT_EOF_EN
          eof_d   = 1'b0;
        end else if (req && src_eof) begin
          // Buffered data always drains before EOF is reported.
          state_d = IO_DOWORK;
          eof_d   = 1'b1;
`endif
        end
      end
      IO_DOWORK: begin
        state_d = IO_WAITACK;
`ifdef IO_INPUT_EOF_EN
        if (eof_q) begin
          data_d = '1;
        end else begin
          fifo_pop = 1'b1;
          data_d   = WORD_SIZE'(fifo_head);
        end
`else
        fifo_pop = 1'b1;
        data_d   = WORD_SIZE'(fifo_head);
`endif
      end
      IO_WAITACK: begin
        if (!req) state_d = IO_WAITREQ;
      end
      default: state_d = IO_WAITREQ;
    endcase
  end

  assign ack  = (state_q == IO_WAITACK);
  assign data = data_q;

endmodule

`default_nettype wire
